// File: rtl/result_checker_param.sv
// Memory-mapped self-check monitor: snoops the data-memory write bus, arms on a begin
// symbol at the test port, then scores each later test-port write against a loadable table.
module result_checker_param #(
  parameter int                  ADDR_W     = 30,
  parameter int                  DATA_W     = 32,
  parameter logic [ADDR_W-1:0]   TEST_PORT  = 'hFF,
  parameter logic [DATA_W-1:0]   BEGIN_SYM  = 'h168,
  parameter int                  CHECK_NUM  = 33,
  parameter int                  DEPTH      = 64,
  parameter int                  IDX_W      = 6,
  parameter bit                  SWAP_BYTES = 1'b1,
  parameter bit                  DEDUP      = 1'b1,
  parameter logic [15:0]         TIMEOUT    = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  output logic [7:0]        error_num,
  output logic [15:0]       duration,
  output logic              finish,
  output logic              timeout,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic              pass
);

  localparam int               NB       = DATA_W / 8;
  localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_ONES = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHECK_NUM - 1);
  localparam logic [IDX_W:0]   DEPTH_W  = (IDX_W + 1)'(DEPTH);
  localparam logic [15:0]      TO_LAST  = TIMEOUT - 16'd1;

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               armed;
  logic [DATA_W-1:0]  tbl [DEPTH];

  logic [DATA_W-1:0]  swapped, dm, exp_val;
  logic               hit, acc, mism, last, wd;

  // Bus is little-endian; reverse bytes so comparisons use readable order.
  for (genvar b = 0; b < NB; b++) begin : g_swap
    assign swapped[8*b +: 8] = data[8*(NB-1-b) +: 8];
  end

  always_comb begin
    dm      = SWAP_BYTES ? swapped : data;
    hit     = wen && (addr == TEST_PORT);
    acc     = hit && (!DEDUP || armed);
    exp_val = tbl[idx[AW-1:0]];
    mism    = (dm != exp_val);
    last    = (idx == LAST_IDX);
    wd      = (TIMEOUT != 16'd0) && (duration == TO_LAST);
  end

  // Table loads only while idle so a running check cannot be disturbed.
  always_ff @(posedge clk) begin
    if (exp_we && state == IDLE && ({1'b0, exp_idx} < DEPTH_W))
      tbl[exp_idx[AW-1:0]] <= exp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      armed         <= 1'b1;
      error_num     <= 8'hFF;
      duration      <= 16'd0;
      finish        <= 1'b0;
      timeout       <= 1'b0;
      first_err_idx <= IDX_ONES;
      pass          <= 1'b0;
    end else begin
      // A stalled store keeps wen high; only the first cycle of each burst is armed.
      armed <= ~wen;
      case (state)
        IDLE: begin
          if (acc && dm == BEGIN_SYM) begin
            state     <= CHECK;
            error_num <= 8'd0;
            duration  <= 16'd0;
            idx       <= '0;
          end
        end
        CHECK: begin
          if (duration != 16'hFFFF) duration <= duration + 16'd1;
          if (acc) begin
            if (mism) begin
              if (error_num != 8'hFF) error_num <= error_num + 8'd1;
              if (first_err_idx == IDX_ONES) first_err_idx <= idx;
`ifndef SYNTHESIS
              $display("result_checker: idx %0d expected %h got %h at %0t",
                       idx, exp_val, dm, $time);
`endif
            end
            idx <= idx + IDX_W'(1);
          end
          // The final write beats the watchdog when both land together.
          if (acc && last) begin
            state  <= REPORT;
            finish <= 1'b1;
            pass   <= (error_num == 8'd0) && !mism;
          end else if (wd) begin
            state   <= REPORT;
            finish  <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        REPORT: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_checker_param.sv
// Directed bench for result_checker_param: default, no-dedup and short-watchdog instances
// share one bus; each scenario checks the instance it targets.
module tb_result_checker_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        exp_we;
  logic [5:0]  exp_idx;
  logic [31:0] exp_data;

  logic [7:0]  err_a, err_n, err_t;
  logic [15:0] dur_a, dur_n, dur_t;
  logic        fin_a, fin_n, fin_t;
  logic        to_a,  to_n,  to_t;
  logic [5:0]  fei_a, fei_n, fei_t;
  logic        pas_a, pas_n, pas_t;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] t [33];

  always #5 clk = ~clk;

  result_checker_param dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
    .error_num(err_a), .duration(dur_a), .finish(fin_a), .timeout(to_a),
    .first_err_idx(fei_a), .pass(pas_a));

  result_checker_param #(.DEDUP(1'b0)) dut_nd (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
    .error_num(err_n), .duration(dur_n), .finish(fin_n), .timeout(to_n),
    .first_err_idx(fei_n), .pass(pas_n));

  result_checker_param #(.TIMEOUT(16'd100)) dut_to (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
    .error_num(err_t), .duration(dur_t), .finish(fin_t), .timeout(to_t),
    .first_err_idx(fei_t), .pass(pas_t));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] swap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One write burst held for 'hold' cycles, then one idle cycle.
  task automatic bus_wr(input logic [29:0] a, input logic [31:0] v, input int hold);
    addr = a; data = v; wen = 1'b1;
    repeat (hold) tick();
    wen = 1'b0;
    tick();
  endtask

  task automatic send_begin();
    bus_wr(30'hFF, swap(32'h168), 1);
  endtask

  // Writes table entries first..last in order; entries c1/c2 are corrupted.
  task automatic run_seq(input int first, input int last, input int hold,
                         input int c1, input int c2);
    for (int i = first; i <= last; i++)
      bus_wr(30'hFF, swap(t[i] ^ ((i == c1 || i == c2) ? 32'h1 : 32'h0)), hold);
  endtask

  initial begin
    logic [31:0] up [16];
    up = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};
    for (int i = 0; i < 16; i++) begin
      t[i]      = up[i];
      t[16 + i] = up[15 - i];
    end
    t[32] = 32'hFFFFFD5D;

    rst = 1'b0; addr = '0; data = '0; wen = 1'b0;
    exp_we = 1'b0; exp_idx = '0; exp_data = '0;
    tick();
    do_reset();
    chk("rst_err",   err_a, 8'hFF);
    chk("rst_dur",   dur_a, 16'd0);
    chk("rst_fin",   fin_a, 1'b0);
    chk("rst_fei",   fei_a, 6'h3F);
    chk("rst_pass",  pas_a, 1'b0);
    chk("rst_to",    to_a,  1'b0);

    for (int i = 0; i < 33; i++) begin
      exp_we = 1'b1; exp_idx = 6'(i); exp_data = t[i];
      tick();
    end
    exp_we = 1'b0;

    // Clean run
    send_begin();
    run_seq(0, 32, 1, -1, -1);
    chk("ok_fin",  fin_a, 1'b1);
    chk("ok_err",  err_a, 8'd0);
    chk("ok_pass", pas_a, 1'b1);
    chk("ok_fei",  fei_a, 6'h3F);
    chk("ok_to",   to_a,  1'b0);
    chk("ok_dur",  dur_a, 16'd66);
    chk("ok_nd_pass", pas_n, 1'b1);
    chk("ok_to_pass", pas_t, 1'b1);

    // Two corrupted writes
    do_reset();
    send_begin();
    run_seq(0, 32, 1, 5, 20);
    chk("bad_fin",  fin_a, 1'b1);
    chk("bad_err",  err_a, 8'd2);
    chk("bad_fei",  fei_a, 6'd5);
    chk("bad_pass", pas_a, 1'b0);

    // Stalled writes: 3-cycle bursts
    do_reset();
    send_begin();
    run_seq(0, 10, 3, -1, -1);
    chk("stall_nd_fin", fin_n, 1'b1);
    chk("stall_nd_err", err_n, 8'd32);
    chk("stall_nd_fei", fei_n, 6'd1);
    chk("stall_a_busy", fin_a, 1'b0);
    run_seq(11, 32, 3, -1, -1);
    chk("stall_a_fin",  fin_a, 1'b1);
    chk("stall_a_err",  err_a, 8'd0);
    chk("stall_a_pass", pas_a, 1'b1);

    // Watchdog
    do_reset();
    send_begin();
    run_seq(0, 9, 1, -1, -1);
    for (int k = 0; k < 300 && !fin_t; k++) tick();
    chk("wd_fin",  fin_t, 1'b1);
    chk("wd_dur",  dur_t, 16'd100);
    chk("wd_to",   to_t,  1'b1);
    chk("wd_err",  err_t, 8'd0);
    chk("wd_pass", pas_t, 1'b0);
    chk("wd_a_busy", fin_a, 1'b0);
    chk("wd_a_err",  err_a, 8'd0);

    // Wrong port does not arm; table writes during CHECK are ignored
    do_reset();
    bus_wr(30'hFE, swap(32'h168), 1);
    tick();
    chk("port_err", err_a, 8'hFF);
    chk("port_dur", dur_a, 16'd0);
    send_begin();
    exp_we = 1'b1; exp_idx = 6'd0; exp_data = 32'hDEAD;
    tick();
    exp_we = 1'b0;
    run_seq(0, 32, 1, -1, -1);
    chk("tbl_fin",  fin_a, 1'b1);
    chk("tbl_pass", pas_a, 1'b1);

    // Reset in the middle of a run, then a fresh run
    do_reset();
    send_begin();
    run_seq(0, 11, 1, -1, -1);
    do_reset();
    chk("abort_err", err_a, 8'hFF);
    chk("abort_dur", dur_a, 16'd0);
    chk("abort_fin", fin_a, 1'b0);
    send_begin();
    run_seq(0, 32, 1, -1, -1);
    chk("rerun_fin",  fin_a, 1'b1);
    chk("rerun_pass", pas_a, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
